// File: rtl/adc_trigger.sv
// adc_trigger
//   Trigger-and-capture stage in the ADC clock domain. Samples are written
//   continuously into a DEPTH-entry ring RAM. A level crossing (or an
//   auto-mode timeout) freezes a frame of DEPTH samples with PRE
//   pre-trigger samples. The frame is then streamed out with a valid/ready
//   handshake and start/last markers.
//
// Ports
//   clkADC     sample clock, one ADC sample per cycle
//   reset      synchronous, active-high
//   adc_data   unsigned ADC sample
//   level      trigger threshold, sampled every cycle
//   falling    0 = rising-edge trigger, 1 = falling-edge trigger
//   mode       0 = auto, 1 = normal, 2 = single, 3 = normal
//   arm        single-cycle pulse; leaves IDLE
//   out_data   frame sample
//   out_valid  out_data valid
//   out_ready  consumer accepts when out_valid && out_ready
//   out_start  marks frame sample 0
//   out_last   marks frame sample DEPTH-1
//   triggered  frame came from a real crossing, not from the auto timeout
//   busy       high in every state except IDLE
module adc_trigger #(
    parameter int N     = 10,
    parameter int DEPTH = 256,
    parameter int PRE   = 64,
    parameter int AUTO  = 65536
) (
    input  logic         clkADC,
    input  logic         reset,
    input  logic [N-1:0] adc_data,
    input  logic [N-1:0] level,
    input  logic         falling,
    input  logic [1:0]   mode,
    input  logic         arm,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_start,
    output logic         out_last,
    output logic         triggered,
    output logic         busy
);

    localparam int AW  = $clog2(DEPTH);
    localparam int AUW = (AUTO > 1) ? $clog2(AUTO) : 1;

    localparam logic [AW:0]    C_FILL_LAST = (AW+1)'(PRE - 1);
    localparam logic [AW:0]    C_POST_LAST = (AW+1)'(DEPTH - PRE - 2);
    localparam logic [AW:0]    C_DEPTH     = (AW+1)'(DEPTH);
    localparam logic [AW:0]    C_LAST      = (AW+1)'(DEPTH - 1);
    localparam logic [AUW-1:0] C_AUTO_LAST = AUW'(AUTO - 1);
    localparam logic [AW-1:0]  C_PRE       = AW'(PRE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ARMED,
        S_POST,
        S_READ
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [N-1:0]   r_mem [DEPTH];
    logic [AW-1:0]  r_wp;
    logic [AW-1:0]  r_start;
    logic [AW:0]    r_cnt;       // FILL/POST write count, READ issue count
    logic [AUW-1:0] r_auto;
    logic [N-1:0]   r_prev;
    logic           r_prev_vld;
    logic [1:0]     r_mode;      // mode as latched at the last transition
    logic           r_trig;
    logic [N-1:0]   r_data;
    logic           r_valid;
    logic           r_first;
    logic           r_last;

    logic           w_write;
    logic           w_rise;
    logic           w_fall;
    logic           w_cross;
    logic           w_timeout;
    logic           w_fire;
    logic           w_issue;
    logic           w_done;
    logic [AW-1:0]  w_raddr;

    assign w_write   = (r_state == S_FILL) || (r_state == S_ARMED) || (r_state == S_POST);
    assign w_rise    = (r_prev < level) && (adc_data >= level);
    assign w_fall    = (r_prev > level) && (adc_data <= level);
    assign w_cross   = r_prev_vld && (falling ? w_fall : w_rise);
    assign w_timeout = (r_mode == 2'd0) && (r_auto == C_AUTO_LAST);
    assign w_fire    = (r_state == S_ARMED) && (w_cross || w_timeout);
    // A new read is issued only when the output register is empty or being drained.
    assign w_issue   = (r_state == S_READ) && (r_cnt < C_DEPTH) && (!r_valid || out_ready);
    assign w_done    = r_valid && out_ready && r_last;
    assign w_raddr   = r_start + r_cnt[AW-1:0];

    always_ff @(posedge clkADC) begin
        if (reset) begin
            r_state <= (mode == 2'd2) ? S_IDLE : S_FILL;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (arm) w_next = S_FILL;
            S_FILL:  if (r_cnt == C_FILL_LAST) w_next = S_ARMED;
            S_ARMED: if (w_fire) w_next = S_POST;
            S_POST:  if (r_cnt == C_POST_LAST) w_next = S_READ;
            S_READ:  if (w_done) w_next = (mode == 2'd2) ? S_IDLE : S_FILL;
            default: w_next = S_FILL;
        endcase
    end

    always_ff @(posedge clkADC) begin
        if (w_write && !reset) begin
            r_mem[r_wp] <= adc_data;
        end
    end

    always_ff @(posedge clkADC) begin
        if (reset) begin
            r_wp       <= '0;
            r_start    <= '0;
            r_cnt      <= '0;
            r_auto     <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_mode     <= mode;
            r_trig     <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            if (w_write) begin
                r_wp       <= r_wp + 1'b1;
                r_prev     <= adc_data;
                r_prev_vld <= 1'b1;
            end
            // Entering FILL invalidates prev; no writes precede FILL, so this wins.
            if (w_next == S_FILL && r_state != S_FILL) begin
                r_prev_vld <= 1'b0;
            end

            if (w_next != r_state) begin
                r_mode <= mode;
                r_cnt  <= '0;
            end else if (r_state == S_FILL || r_state == S_POST || w_issue) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == S_ARMED && w_next == S_ARMED && r_mode == 2'd0) begin
                r_auto <= r_auto + 1'b1;
            end else begin
                r_auto <= '0;
            end

            if (w_fire) begin
                r_start <= r_wp - C_PRE;
                r_trig  <= w_cross;
            end else if (w_done) begin
                r_trig <= 1'b0;
            end

            if (w_issue) begin
                r_data  <= r_mem[w_raddr];
                r_valid <= 1'b1;
                r_first <= (r_cnt == '0);
                r_last  <= (r_cnt == C_LAST);
            end else if (out_ready) begin
                r_valid <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_start = r_first;
    assign out_last  = r_last;
    assign triggered = r_trig;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_adc_trigger.sv
// tb_adc_trigger
//   Directed bench for adc_trigger with DEPTH=16, PRE=4, AUTO=32, level=512.
//   Each scenario feeds a per-cycle stimulus, collects accepted beats and
//   compares them against hand-computed frames.
module tb_adc_trigger;

    localparam int N     = 10;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    localparam int AUTO  = 32;

    logic         clkADC = 1'b0;
    logic         reset;
    logic [N-1:0] adc_data;
    logic [N-1:0] level;
    logic         falling;
    logic [1:0]   mode;
    logic         arm;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_start;
    logic         out_last;
    logic         triggered;
    logic         busy;

    always #5 clkADC = ~clkADC;

    adc_trigger #(
        .N(N),
        .DEPTH(DEPTH),
        .PRE(PRE),
        .AUTO(AUTO)
    ) dut (
        .clkADC(clkADC),
        .reset(reset),
        .adc_data(adc_data),
        .level(level),
        .falling(falling),
        .mode(mode),
        .arm(arm),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_start(out_start),
        .out_last(out_last),
        .triggered(triggered),
        .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int sel      = 0;
    int bp       = 0;
    int nbeats;
    int first_valid;
    int b_data  [32];
    int b_start [32];
    int b_last  [32];
    int b_trig  [32];
    int exp_data[16];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] stim(input int k);
        case (sel)
            1:       stim = N'(656 - 8 * k);
            2:       stim = (k == 1) ? N'(600) : (k == 10) ? N'(700) : (k > 10) ? N'(k) : N'(0);
            3:       stim = N'(100);
            default: stim = N'((64 * k) % 1024);
        endcase
    endfunction

    function automatic logic rdy_pat(input int k);
        case (k % 4)
            0:       rdy_pat = 1'b1;
            1:       rdy_pat = 1'b0;
            2:       rdy_pat = 1'b0;
            default: rdy_pat = 1'b1;
        endcase
    endfunction

    task automatic do_reset(input int exp_busy);
        reset     = 1'b1;
        adc_data  = '0;
        arm       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clkADC);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_start", int'(out_start), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_trig", int'(triggered), 0);
        chk("rst_busy", int'(busy), exp_busy);
        reset = 1'b0;
    endtask

    // Runs up to ncyc cycles, stopping after the out_last beat is accepted.
    task automatic run(input int ncyc, input bit arm_first);
        bit done;
        bit have_hold;
        int h_data;
        int h_mark;
        nbeats      = 0;
        first_valid = -1;
        done        = 1'b0;
        have_hold   = 1'b0;
        h_data      = 0;
        h_mark      = 0;
        for (int i = 0; i < 32; i++) begin
            b_data[i]  = -1;
            b_start[i] = -1;
            b_last[i]  = -1;
            b_trig[i]  = -1;
        end
        for (int k = 0; k < ncyc && !done; k++) begin
            adc_data  = stim(k);
            out_ready = (bp != 0) ? rdy_pat(k) : 1'b1;
            arm       = arm_first && (k == 0);
            if (have_hold) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_data", int'(out_data), h_data);
                chk("hold_mark", int'({out_start, out_last}), h_mark);
            end
            have_hold = out_valid && !out_ready;
            h_data    = int'(out_data);
            h_mark    = int'({out_start, out_last});
            if (out_valid && first_valid < 0) first_valid = k;
            if (out_valid && out_ready) begin
                if (nbeats < 32) begin
                    b_data[nbeats]  = int'(out_data);
                    b_start[nbeats] = int'(out_start);
                    b_last[nbeats]  = int'(out_last);
                    b_trig[nbeats]  = int'(triggered);
                end
                nbeats++;
                if (out_last) done = 1'b1;
            end
            @(posedge clkADC);
            #1;
        end
        arm = 1'b0;
    endtask

    task automatic check_frame(input string nm, input int exp_trig);
        chk($sformatf("%s_nbeats", nm), nbeats, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("%s_data%0d", nm, i), b_data[i], exp_data[i]);
            chk($sformatf("%s_start%0d", nm, i), b_start[i], (i == 0) ? 1 : 0);
            chk($sformatf("%s_last%0d", nm, i), b_last[i], (i == DEPTH - 1) ? 1 : 0);
            chk($sformatf("%s_trig%0d", nm, i), b_trig[i], exp_trig);
        end
    endtask

    initial begin
        reset     = 1'b1;
        level     = N'(512);
        falling   = 1'b0;
        mode      = 2'd1;
        arm       = 1'b0;
        out_ready = 1'b1;
        adc_data  = '0;

        // Rising ramp: crossing at k=8 (512), frame is samples k=4..19.
        do_reset(1);
        sel = 0;
        for (int i = 0; i < DEPTH; i++) exp_data[i] = (64 * (4 + i)) % 1024;
        run(100, 1'b0);
        check_frame("ramp", 1);
        chk("ramp_beat0", b_data[0], 256);
        chk("ramp_beat4", b_data[4], 512);
        chk("ramp_latency", int'(first_valid >= 21 && first_valid <= 22), 1);
        chk("ramp_busy_after", int'(busy), 1);

        // Falling down-ramp 656-8k: crossing at write 18 (address 2), start = 14.
        falling = 1'b1;
        do_reset(1);
        sel = 1;
        for (int i = 0; i < DEPTH; i++) exp_data[i] = 656 - 8 * (14 + i);
        run(100, 1'b0);
        check_frame("fall", 1);
        chk("fall_beat4", b_data[4], 512);
        falling = 1'b0;

        // Crossing during FILL is ignored; real trigger at k=10, start at write 6.
        do_reset(1);
        sel = 2;
        for (int i = 0; i < DEPTH; i++) exp_data[i] = (i < 4) ? 0 : (i == 4) ? 700 : 6 + i;
        run(100, 1'b0);
        check_frame("fillx", 1);
        chk("fillx_latency", int'(first_valid >= 23 && first_valid <= 24), 1);

        // Auto mode with constant input: forced trigger after 4+32 cycles, 11 post writes.
        mode = 2'd0;
        do_reset(1);
        sel = 3;
        for (int i = 0; i < DEPTH; i++) exp_data[i] = 100;
        run(150, 1'b0);
        check_frame("auto", 0);
        chk("auto_latency", int'(first_valid >= 48 && first_valid <= 49), 1);

        // Backpressure with ready pattern 1,0,0,1.
        mode = 2'd1;
        do_reset(1);
        sel = 0;
        bp  = 1;
        for (int i = 0; i < DEPTH; i++) exp_data[i] = (64 * (4 + i)) % 1024;
        run(200, 1'b0);
        check_frame("bp", 1);
        bp = 0;

        // Single mode: nothing until arm, one frame, then IDLE again.
        mode = 2'd2;
        do_reset(0);
        sel = 0;
        run(40, 1'b0);
        chk("single_noarm_beats", nbeats, 0);
        chk("single_noarm_busy", int'(busy), 0);
        run(100, 1'b1);
        check_frame("single", 1);
        chk("single_busy_after", int'(busy), 0);
        run(60, 1'b0);
        chk("single_rearm_beats", nbeats, 0);
        chk("single_rearm_busy", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
